// File: rtl/vme_wr_pkg.sv
// Shared definitions for the VME write-side byte assembler.
package vme_wr_pkg;

    // Lane-select encoding, identical to the read-side byte mux.
    localparam logic [1:0] LANE0_SEL = 2'b11;
    localparam logic [1:0] LANE1_SEL = 2'b10;
    localparam logic [1:0] LANE2_SEL = 2'b01;
    localparam logic [1:0] LANE3_SEL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_COMMIT = 2'd2
    } wr_state_t;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/vme_lane_dec.sv
// Byte-lane decoder: wr_sel to one-hot lane mask and placed data word.
module vme_lane_dec
    import vme_wr_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [7:0]  data,
    output logic [3:0]  lane,
    output logic [31:0] word
);

    // Decode lane select and steer the byte into its lane.
    always_comb begin
        lane = '0;
        word = '0;
        case (sel)
            LANE0_SEL: begin lane = 4'b0001; word[7:0]   = data; end
            LANE1_SEL: begin lane = 4'b0010; word[15:8]  = data; end
            LANE2_SEL: begin lane = 4'b0100; word[23:16] = data; end
            LANE3_SEL: begin lane = 4'b1000; word[31:24] = data; end
            default:   begin lane = '0;      word = '0;          end
        endcase
    end

endmodule

// File: rtl/vme_wr_assembler.sv
// VME64 slave write assembler: merges byte writes into words and hands
// completed words to the local register bus over valid/ready.
module vme_wr_assembler
    import vme_wr_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int FLUSH_TO = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_stb,
    input  logic              wr_d32,
    input  logic [1:0]        wr_sel,
    input  logic [7:0]        wr_data,
    input  logic [31:0]       wr_word,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              flush,
    output logic              wr_busy,
    output logic              overrun,
    output logic              lb_valid,
    input  logic              lb_ready,
    output logic [ADDR_W-1:0] lb_addr,
    output logic [31:0]       lb_data,
    output logic [3:0]        lb_be
);

    localparam int CNT_W = (FLUSH_TO > 1) ? $clog2(FLUSH_TO) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((FLUSH_TO > 0) ? FLUSH_TO - 1 : 0);

    wr_state_t         state_q, state_d;
    logic              valid_d, busy_d, overrun_d;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_word;
    logic              pend_vld, pend_d32;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_data;
    logic [3:0]        pend_be;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              same_addr, timeout, handshake;
    logic [3:0]        merged_be;
    logic [31:0]       merged_data;

    vme_lane_dec u_lane_dec (
        .sel  (wr_sel),
        .data (wr_data),
        .lane (lane_mask),
        .word (lane_word)
    );

    // The shadow word lives directly in lb_addr/lb_data/lb_be so the bus
    // outputs are registered without a second copy.
    assign same_addr   = !wr_d32 && (wr_addr == lb_addr);
    assign merged_be   = lb_be | lane_mask;
    assign merged_data = (lb_data & ~be_to_mask(lane_mask)) | lane_word;
    assign timeout     = (FLUSH_TO != 0) && (tmo_cnt == TMO_LAST);
    assign handshake   = lb_valid && lb_ready;

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lb_valid <= 1'b0;
            wr_busy  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lb_valid <= valid_d;
            wr_busy  <= busy_d;
            overrun  <= overrun_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_stb) state_d = wr_d32 ? ST_COMMIT : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (wr_stb) begin
                    if (!same_addr || flush || (merged_be == 4'b1111)) state_d = ST_COMMIT;
                end else if (flush || timeout) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (handshake) begin
                    if (!pend_vld)     state_d = ST_IDLE;
                    else if (pend_d32) state_d = ST_COMMIT;
                    else               state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered control outputs.
    always_comb begin
        valid_d   = (state_d == ST_COMMIT);
        busy_d    = (state_d == ST_COMMIT);
        overrun_d = wr_stb && (state_q == ST_COMMIT);
    end

    // Shadow word, pending entry and idle timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            lb_addr   <= '0;
            lb_data   <= '0;
            lb_be     <= '0;
            pend_vld  <= 1'b0;
            pend_d32  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            pend_be   <= '0;
            tmo_cnt   <= '0;
        end else begin
            tmo_cnt <= (state_q == ST_ACCUM && !wr_stb) ? tmo_cnt + CNT_W'(1) : '0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_stb) begin
                        lb_addr <= wr_addr;
                        lb_data <= wr_d32 ? wr_word : lane_word;
                        lb_be   <= wr_d32 ? 4'b1111 : lane_mask;
                    end
                end
                ST_ACCUM: begin
                    if (wr_stb) begin
                        if (same_addr) begin
                            lb_data <= merged_data;
                            lb_be   <= merged_be;
                        end else begin
                            pend_vld  <= 1'b1;
                            pend_d32  <= wr_d32;
                            pend_addr <= wr_addr;
                            pend_data <= wr_d32 ? wr_word : lane_word;
                            pend_be   <= wr_d32 ? 4'b1111 : lane_mask;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (handshake && pend_vld) begin
                        lb_addr  <= pend_addr;
                        lb_data  <= pend_data;
                        lb_be    <= pend_be;
                        pend_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vme_wr_assembler.sv
// Directed bench for vme_wr_assembler with a commit scoreboard.
module tb_vme_wr_assembler;

    logic        clk;
    logic        reset;
    logic        wr_stb;
    logic        wr_d32;
    logic [1:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [31:0] wr_word;
    logic [15:0] wr_addr;
    logic        flush;
    logic        wr_busy;
    logic        overrun;
    logic        lb_valid;
    logic        lb_ready;
    logic [15:0] lb_addr;
    logic [31:0] lb_data;
    logic [3:0]  lb_be;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vme_wr_assembler #(.ADDR_W(16), .FLUSH_TO(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_stb   (wr_stb),
        .wr_d32   (wr_d32),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .wr_word  (wr_word),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .wr_busy  (wr_busy),
        .overrun  (overrun),
        .lb_valid (lb_valid),
        .lb_ready (lb_ready),
        .lb_addr  (lb_addr),
        .lb_data  (lb_data),
        .lb_be    (lb_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_wr(input logic [15:0] a, input logic [1:0] s, input logic [7:0] d);
        wr_stb = 1'b1; wr_d32 = 1'b0; wr_addr = a; wr_sel = s; wr_data = d;
        step();
        wr_stb = 1'b0;
    endtask

    task automatic word_wr(input logic [15:0] a, input logic [31:0] w);
        wr_stb = 1'b1; wr_d32 = 1'b1; wr_addr = a; wr_word = w;
        step();
        wr_stb = 1'b0; wr_d32 = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (reset === 1'b0 && lb_valid === 1'b1 && lb_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", {16'h0, lb_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_addr", {16'h0, lb_addr}, {16'h0, e.addr});
                chk("commit_data", lb_data, e.data);
                chk("commit_be", {28'h0, lb_be}, {28'h0, e.be});
            end
        end
    end

    initial begin
        logic [31:0] held;
        int lat;
        bit  seen;

        reset = 1'b1; wr_stb = 1'b0; wr_d32 = 1'b0; wr_sel = 2'b00; wr_data = '0;
        wr_word = '0; wr_addr = '0; flush = 1'b0; lb_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", {31'h0, lb_valid}, 32'h0);
        chk("rst_busy", {31'h0, wr_busy}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_addr", {16'h0, lb_addr}, 32'h0);
        chk("rst_data", lb_data, 32'h0);
        chk("rst_be", {28'h0, lb_be}, 32'h0);

        // Four byte lanes to 0x10 make one full word.
        lb_ready = 1'b1;
        sb.push_back('{addr: 16'h0010, data: 32'h4433_2211, be: 4'b1111});
        byte_wr(16'h0010, 2'b11, 8'h11);
        byte_wr(16'h0010, 2'b10, 8'h22);
        byte_wr(16'h0010, 2'b01, 8'h33);
        chk("t1_valid_early", {31'h0, lb_valid}, 32'h0);
        byte_wr(16'h0010, 2'b00, 8'h44);
        chk("t1_valid", {31'h0, lb_valid}, 32'h1);
        chk("t1_busy", {31'h0, wr_busy}, 32'h1);
        step();
        chk("t1_idle_valid", {31'h0, lb_valid}, 32'h0);
        chk("t1_idle_busy", {31'h0, wr_busy}, 32'h0);

        // Partial word committed by flush.
        sb.push_back('{addr: 16'h0020, data: 32'h0000_AA00, be: 4'b0010});
        byte_wr(16'h0020, 2'b10, 8'hAA);
        do_flush();
        chk("t2_valid", {31'h0, lb_valid}, 32'h1);
        step();

        // Address change commits old word, new byte goes pending; bus stalls.
        lb_ready = 1'b0;
        sb.push_back('{addr: 16'h0030, data: 32'h0000_0055, be: 4'b0001});
        byte_wr(16'h0030, 2'b11, 8'h55);
        byte_wr(16'h0031, 2'b00, 8'hBB);
        chk("t3_valid", {31'h0, lb_valid}, 32'h1);
        held = lb_data;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_valid", {31'h0, lb_valid}, 32'h1);
            chk("t3_hold_data", lb_data, held);
            chk("t3_no_overrun", {31'h0, overrun}, 32'h0);
        end
        lb_ready = 1'b1;
        step();
        chk("t3_pend_valid", {31'h0, lb_valid}, 32'h0);
        chk("t3_pend_be", {28'h0, lb_be}, 32'h8);
        chk("t3_pend_addr", {16'h0, lb_addr}, 32'h31);
        sb.push_back('{addr: 16'h0031, data: 32'hBB00_0000, be: 4'b1000});
        do_flush();
        chk("t3b_valid", {31'h0, lb_valid}, 32'h1);
        step();

        // D32 while stalled, then a strobe while busy is dropped.
        lb_ready = 1'b0;
        sb.push_back('{addr: 16'h0040, data: 32'hDEAD_BEEF, be: 4'b1111});
        word_wr(16'h0040, 32'hDEAD_BEEF);
        chk("t4_busy", {31'h0, wr_busy}, 32'h1);
        chk("t4_no_overrun", {31'h0, overrun}, 32'h0);
        byte_wr(16'h0041, 2'b11, 8'h99);
        chk("t4_overrun", {31'h0, overrun}, 32'h1);
        step();
        chk("t4_overrun_pulse", {31'h0, overrun}, 32'h0);
        lb_ready = 1'b1;
        step();
        chk("t4_done_valid", {31'h0, lb_valid}, 32'h0);
        step();

        // Timeout commit: lb_valid 9 cycles after the strobe with FLUSH_TO=8.
        sb.push_back('{addr: 16'h0050, data: 32'h0077_0000, be: 4'b0100});
        byte_wr(16'h0050, 2'b01, 8'h77);
        lat = 1;
        while (lb_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("t5_latency", lat, 32'd9);
        step();

        // Reset in COMMIT with a pending byte drops both.
        lb_ready = 1'b0;
        byte_wr(16'h0060, 2'b11, 8'h01);
        byte_wr(16'h0061, 2'b11, 8'h02);
        chk("t6_valid", {31'h0, lb_valid}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_valid", {31'h0, lb_valid}, 32'h0);
        chk("t6_rst_busy", {31'h0, wr_busy}, 32'h0);
        chk("t6_rst_addr", {16'h0, lb_addr}, 32'h0);
        chk("t6_rst_data", lb_data, 32'h0);
        chk("t6_rst_be", {28'h0, lb_be}, 32'h0);
        lb_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (lb_valid !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_valid", {31'h0, seen}, 32'h0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_wr_assembler.md
# vme_wr_assembler

Write-direction byte-lane steering and word assembler for the VME64 slave. It accepts D08 byte writes (lane-selected) and D32 word writes from the VME slave front end. It merges byte writes to the same word address into a 32-bit shadow word with byte enables. Completed words are handed to the local register bus over a valid/ready handshake.

## Interface
- `ADDR_W`, default 16: local word-address width.
- `FLUSH_TO`, default 255: idle cycles in ACCUM before auto-commit; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_stb`  in  1  one-cycle write strobe from the VME front end.
- `wr_d32`  in  1  qualifies `wr_stb`: 1 = word write using `wr_word`, 0 = byte write using `wr_data`/`wr_sel`.
- `wr_sel`  in  2  byte lane: 2'b11 = lane0 [7:0], 2'b10 = lane1 [15:8], 2'b01 = lane2 [23:16], 2'b00 = lane3 [31:24].
- `wr_data`  in  8  byte write data.
- `wr_word`  in  32  word write data.
- `wr_addr`  in  ADDR_W  word address of the strobe.
- `flush`  in  1  commit any partial word.
- `wr_busy`  out  1  registered; high in COMMIT. Strobes are not accepted while it is high.
- `overrun`  out  1  one-cycle pulse when a strobe arrives while `wr_busy` is high (the strobe is dropped).
- `lb_valid`  out  1  local-bus write request.
- `lb_ready`  in  1  local-bus accept.
- `lb_addr`  out  ADDR_W  committed word address.
- `lb_data`  out  32  committed data; unwritten lanes are 8'h00.
- `lb_be`  out  4  byte enables, bit i = lane i.

## Operation
- States: IDLE (shadow empty), ACCUM (partial word held), COMMIT (`lb_valid`=1).
- IDLE, byte strobe: write the lane into the shadow, set that `be` bit, latch `wr_addr`, go to ACCUM.
- IDLE, D32 strobe: load `wr_word`, set `be`=4'b1111, go to COMMIT.
- IDLE, `flush` alone: ignored.
- ACCUM, byte strobe with the same address: merge the lane; a repeated lane overwrites (last write wins). If `be` becomes 4'b1111, go to COMMIT.
- ACCUM, strobe with a different address or with `wr_d32`=1: commit the current shadow (go to COMMIT) and capture the new strobe into the one-entry pending register.
- ACCUM, `flush` or timeout counter reaching FLUSH_TO: go to COMMIT.
- `flush` together with a same-address strobe: merge first, then commit.
- `flush` together with a mismatching strobe: commit the old word; the new strobe goes to pending and is not flushed.
- COMMIT: hold `lb_*` stable until `lb_valid`&`lb_ready`. On the handshake:
  - pending byte: load into the shadow and go to ACCUM;
  - pending D32: reload and stay in COMMIT;
  - no pending entry: go to IDLE.
- COMMIT, any `wr_stb`: `overrun` pulse, strobe dropped, no state change.
- Timeout counter: clears on every accepted strobe and on entry to ACCUM; counts only in ACCUM.

## Timing
- Reset values: `lb_valid`=0, `lb_addr`=0, `lb_data`=0, `lb_be`=0, `wr_busy`=0, `overrun`=0. State = IDLE, pending entry empty, timeout counter = 0.
- Reset during COMMIT drops the word and the pending entry without a handshake.
- All outputs are registered.
- A strobe or flush that triggers a commit at cycle N gives `lb_valid`=1 and `wr_busy`=1 at N+1.
- `lb_ready` already high at N+1 completes the transfer at N+1. The next state (IDLE, ACCUM, or a reloaded COMMIT) is visible at N+2.
- Back-to-back D32 writes: the second strobe is accepted only when `wr_busy`=0. Minimum 2 cycles per word with `lb_ready` tied high.
- Timeout: the last accepted byte at cycle N commits at N+FLUSH_TO, with `lb_valid` at N+FLUSH_TO+1.
- `lb_ready` while `lb_valid`=0 is ignored.

## Structure
- Shared package `vme_wr_pkg`:
  - lane-select encoding constants (`LANE0_SEL`=2'b11 … `LANE3_SEL`=2'b00), matching the read-side byte mux;
  - state encoding constants.
- Sub-module `vme_lane_dec`: combinational `wr_sel` → one-hot 4-bit lane mask and 32-bit data placement.
- The top level holds the FSM, shadow register, pending register and timeout counter.

## Test plan
- Byte writes to address 0x10, in order sel 11/10/01/00 with data 0x11/0x22/0x33/0x44 and `lb_ready`=1 → one commit: `lb_data`=0x44332211, `lb_be`=4'b1111, `lb_addr`=0x10, `lb_valid` the cycle after the 4th strobe.
- Byte 0xAA on sel 10 to address 0x20, then `flush` → `lb_data`=0x0000AA00, `lb_be`=4'b0010.
- Byte to 0x30 on sel 11, then byte 0xBB to 0x31 on sel 00, with `lb_ready` low for 3 cycles → 0x30 word held stable, `overrun` stays low. After the handshake, state is ACCUM holding `be`=4'b1000 at 0x31.
- D32 write 0xDEADBEEF with `lb_ready` low, then a strobe while busy → `overrun` pulses once, only 0xDEADBEEF is committed, `be`=4'b1111.
- FLUSH_TO=8, single byte, no further activity → `lb_valid` exactly 9 cycles after the strobe.
- `reset` asserted during COMMIT with a pending entry → next cycle all outputs are at reset values, and there is no `lb_valid` afterward.
